// File: rtl/instr_exec_sequencer.sv
// instr_exec_sequencer
//
// Runs a batch of instructions held in the instruction register. For each
// entry it reads {opcode, op_a, op_b}, either resolves it locally (ZERO,
// illegal opcode, divide/modulo by zero) or sends it to the shared ALU over a
// valid/ready request channel. It then waits for the 64-bit result and writes
// the result back to the same entry.
//
// Opcode map: 0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MUL, 6 DIV, 7 MOD;
// opcodes 8..15 are illegal.
//
// Ports
//   i_clk, i_reset_n          clock, async active-low reset
//   i_start                   one-cycle batch request (sampled in IDLE only)
//   i_first_addr, i_num_instr first entry and batch length (clamped to MAX_COUNT)
//   o_busy, o_done            busy outside IDLE, one-cycle end-of-batch pulse
//   o_rd_addr, i_rd_*         register read port (data valid one cycle later)
//   o_alu_req_valid/ready     ALU request handshake, payload o_alu_opc/op_a/op_b
//   i_alu_rsp_valid/result    ALU response
//   o_wr_en/addr/result       result write-back
//   o_err_count               skipped instructions in the current batch (saturating)
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for i_start
// FETCH | o_rd_addr = current pointer
// DECODE| read data valid; latch payload, classify local vs ALU
// ISSUE | request valid, held until ready is sampled high
// WAIT  | waiting for the ALU response
// WRITE | write-back strobe; advance pointer or finish
// DONE  | one-cycle done pulse
module instr_exec_sequencer #(
    parameter int NUM_ENTRIES = 32,
    parameter int MAX_COUNT   = 32
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_start,
    input  logic [$clog2(NUM_ENTRIES)-1:0] i_first_addr,
    input  logic [5:0]                     i_num_instr,
    output logic                           o_busy,
    output logic                           o_done,
    output logic [$clog2(NUM_ENTRIES)-1:0] o_rd_addr,
    input  logic [3:0]                     i_rd_opc,
    input  logic [31:0]                    i_rd_op_a,
    input  logic [31:0]                    i_rd_op_b,
    output logic                           o_alu_req_valid,
    input  logic                           i_alu_req_ready,
    output logic [3:0]                     o_alu_opc,
    output logic [31:0]                    o_alu_op_a,
    output logic [31:0]                    o_alu_op_b,
    input  logic                           i_alu_rsp_valid,
    input  logic [63:0]                    i_alu_result,
    output logic                           o_wr_en,
    output logic [$clog2(NUM_ENTRIES)-1:0] o_wr_addr,
    output logic [63:0]                    o_wr_result,
    output logic [5:0]                     o_err_count
);

    localparam int AW = $clog2(NUM_ENTRIES);

    localparam logic [3:0] OPC_ZERO = 4'd0;
    localparam logic [3:0] OPC_DIV  = 4'd6;
    localparam logic [3:0] OPC_MOD  = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_ptr;
    logic [5:0]    r_remain;

    logic          w_local;
    logic          w_err;
    logic [5:0]    w_clamped;
    logic [AW-1:0] w_ptr_inc;

    assign w_clamped = (i_num_instr > 6'(MAX_COUNT)) ? 6'(MAX_COUNT) : i_num_instr;
    assign w_ptr_inc = (r_ptr == AW'(NUM_ENTRIES - 1)) ? '0 : r_ptr + 1'b1;

    always_comb begin
        w_next  = r_state;
        w_local = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_num_instr == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                if (i_rd_opc >= 4'd8) begin
                    w_local = 1'b1;
                    w_err   = 1'b1;
                end else if ((i_rd_opc == OPC_DIV || i_rd_opc == OPC_MOD) && i_rd_op_b == '0) begin
                    w_local = 1'b1;
                    w_err   = 1'b1;
                end else if (i_rd_opc == OPC_ZERO) begin
                    w_local = 1'b1;
                end
                w_next = w_local ? S_WRITE : S_ISSUE;
            end
            S_ISSUE: begin
                if (i_alu_req_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_alu_rsp_valid) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: w_next = (r_remain == 6'd1) ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so every output is a flop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_remain        <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_alu_req_valid <= 1'b0;
            o_wr_en         <= 1'b0;
            o_rd_addr       <= '0;
            o_wr_addr       <= '0;
            o_alu_opc       <= '0;
            o_alu_op_a      <= '0;
            o_alu_op_b      <= '0;
            o_wr_result     <= '0;
            o_err_count     <= '0;
        end else begin
            r_state         <= w_next;
            o_busy          <= (w_next != S_IDLE);
            o_done          <= (w_next == S_DONE);
            o_alu_req_valid <= (w_next == S_ISSUE);
            o_wr_en         <= (w_next == S_WRITE);
            case (r_state)
                S_IDLE: begin
                    if (i_start && i_num_instr != '0) begin
                        r_ptr       <= i_first_addr;
                        r_remain    <= w_clamped;
                        o_rd_addr   <= i_first_addr;
                        o_err_count <= '0;
                    end
                end
                S_DECODE: begin
                    // Payload only changes here, so it stays stable through ISSUE.
                    o_alu_opc  <= i_rd_opc;
                    o_alu_op_a <= i_rd_op_a;
                    o_alu_op_b <= i_rd_op_b;
                    if (w_local) begin
                        o_wr_addr   <= r_ptr;
                        o_wr_result <= '0;
                    end
                    if (w_err && o_err_count != '1) begin
                        o_err_count <= o_err_count + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_alu_rsp_valid) begin
                        o_wr_addr   <= r_ptr;
                        o_wr_result <= i_alu_result;
                    end
                end
                S_WRITE: begin
                    r_remain <= r_remain - 1'b1;
                    if (r_remain != 6'd1) begin
                        r_ptr     <= w_ptr_inc;
                        o_rd_addr <= w_ptr_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_sequencer.sv
// Self-checking bench for instr_exec_sequencer. Models the instruction register
// and a randomized-latency ALU, and predicts each batch's writes, requests,
// error count and latency from the opcode rules.
module tb_instr_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [5:0]  num_instr = '0;
    logic        busy, done;
    logic [4:0]  rd_addr;
    logic [3:0]  rd_opc = '0;
    logic [31:0] rd_op_a = '0, rd_op_b = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [3:0]  alu_opc;
    logic [31:0] op_a, op_b;
    logic        rsp_valid = 1'b0;
    logic [63:0] alu_result = '0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_result;
    logic [5:0]  err_count;

    always #5 clk = ~clk;

    instr_exec_sequencer dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start),
        .i_first_addr(first_addr), .i_num_instr(num_instr),
        .o_busy(busy), .o_done(done), .o_rd_addr(rd_addr),
        .i_rd_opc(rd_opc), .i_rd_op_a(rd_op_a), .i_rd_op_b(rd_op_b),
        .o_alu_req_valid(req_valid), .i_alu_req_ready(req_ready),
        .o_alu_opc(alu_opc), .o_alu_op_a(op_a), .o_alu_op_b(op_b),
        .i_alu_rsp_valid(rsp_valid), .i_alu_result(alu_result),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_result(wr_result),
        .o_err_count(err_count)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [3:0]  mem_opc [32];
    logic [31:0] mem_a [32];
    logic [31:0] mem_b [32];
    int stall_arr [64];
    int delay_arr [64];
    int batch_base = 0;

    int acc_total = 0, done_total = 0, busy_total = 0, unstable = 0, done_cyc = 0;
    logic [4:0]  wlog_addr [$];
    logic [63:0] wlog_res [$];
    logic [3:0]  rq_opc [$];
    logic [31:0] rq_a [$];
    logic [31:0] rq_b [$];
    int          stall_seen = 0, wait_cnt = 0;
    logic [63:0] pend_res = '0;
    logic        prev_stalled = 1'b0;
    logic [3:0]  prev_opc = '0;
    logic [31:0] prev_a = '0, prev_b = '0;
    logic [4:0]  last_addr = '0;
    int          last_lat = 0;

    function automatic logic [63:0] alu_fn(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            4'd1: return sa;
            4'd2: return sb;
            4'd3: return sa + sb;
            4'd4: return sa - sb;
            4'd5: return sa * sb;
            4'd6: return (sb == 0) ? 64'd0 : sa / sb;
            4'd7: return (sb == 0) ? 64'd0 : sa % sb;
            default: return 64'd0;
        endcase
    endfunction

    // Register model, ALU model and bus monitor, all on the falling edge.
    always @(negedge clk) begin
        int k;
        if (wr_en) begin
            wlog_addr.push_back(wr_addr);
            wlog_res.push_back(wr_result);
        end
        if (done) begin
            done_total = done_total + 1;
            done_cyc = cyc;
        end
        if (busy) busy_total = busy_total + 1;
        if (prev_stalled && (req_valid !== 1'b1 || alu_opc !== prev_opc || op_a !== prev_a || op_b !== prev_b))
            unstable = unstable + 1;
        rd_opc  = mem_opc[last_addr];
        rd_op_a = mem_a[last_addr];
        rd_op_b = mem_b[last_addr];
        last_addr = rd_addr;
        if (!rst_n) begin
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            wait_cnt = 0;
            stall_seen = 0;
            prev_stalled = 1'b0;
        end else begin
            rsp_valid = 1'b0;
            if (wait_cnt > 0) begin
                wait_cnt = wait_cnt - 1;
                if (wait_cnt == 0) begin
                    rsp_valid = 1'b1;
                    alu_result = pend_res;
                end
            end
            k = acc_total - batch_base;
            if (k < 0 || k > 63) k = 0;
            if (req_valid) begin
                if (stall_seen < stall_arr[k]) begin
                    req_ready = 1'b0;
                    stall_seen = stall_seen + 1;
                end else begin
                    req_ready = 1'b1;
                end
            end else begin
                req_ready = 1'b0;
            end
            prev_stalled = req_valid && !req_ready;
            prev_opc = alu_opc;
            prev_a = op_a;
            prev_b = op_b;
            if (req_valid && req_ready) begin
                rq_opc.push_back(alu_opc);
                rq_a.push_back(op_a);
                rq_b.push_back(op_b);
                pend_res = alu_fn(alu_opc, op_a, op_b);
                wait_cnt = delay_arr[k];
                stall_seen = 0;
                acc_total = acc_total + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_valid"}, 64'(req_valid), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_opc"}, 64'(alu_opc), 64'd0);
        check({tag, "_op_a"}, 64'(op_a), 64'd0);
        check({tag, "_op_b"}, 64'(op_b), 64'd0);
        check({tag, "_wr_result"}, wr_result, 64'd0);
        check({tag, "_err"}, 64'(err_count), 64'd0);
    endtask

    task automatic set_fast();
        for (int i = 0; i < 64; i++) begin
            stall_arr[i] = 0;
            delay_arr[i] = 1;
        end
    endtask

    task automatic randomize_all();
        for (int i = 0; i < 32; i++) begin
            mem_opc[i] = ($urandom % 4 == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            mem_a[i] = $urandom;
            mem_b[i] = ($urandom % 5 == 0) ? 32'd0 : $urandom;
        end
        for (int i = 0; i < 64; i++) begin
            stall_arr[i] = $urandom_range(0, 3);
            delay_arr[i] = $urandom_range(1, 3);
        end
    endtask

    task automatic run_batch(input logic [4:0] f, input logic [5:0] n, input bit extra, input string tag);
        int ne, cyc_sum, k, exp_err, w0, r0, d0, b0, t0, addr;
        bit got;
        logic [4:0]  rd_before;
        logic [4:0]  ea [$];
        logic [63:0] er [$];
        logic [3:0]  eo [$];
        logic [31:0] eqa [$];
        logic [31:0] eqb [$];
        logic [3:0]  o;
        logic [31:0] a, b;
        ne = (n > 6'd32) ? 32 : int'(n);
        cyc_sum = 0;
        k = 0;
        exp_err = 0;
        for (int i = 0; i < ne; i++) begin
            addr = (int'(f) + i) % 32;
            o = mem_opc[addr];
            a = mem_a[addr];
            b = mem_b[addr];
            ea.push_back(5'(addr));
            if (o >= 4'd8 || ((o == 4'd6 || o == 4'd7) && b == 32'd0)) begin
                er.push_back(64'd0);
                exp_err++;
                cyc_sum += 3;
            end else if (o == 4'd0) begin
                er.push_back(64'd0);
                cyc_sum += 3;
            end else begin
                eo.push_back(o);
                eqa.push_back(a);
                eqb.push_back(b);
                er.push_back(alu_fn(o, a, b));
                cyc_sum += 5 + stall_arr[k] + delay_arr[k] - 1;
                k++;
            end
        end

        @(posedge clk); #1;
        batch_base = acc_total;
        w0 = wlog_addr.size();
        r0 = rq_opc.size();
        d0 = done_total;
        b0 = busy_total;
        rd_before = rd_addr;
        start = 1'b1;
        first_addr = f;
        num_instr = n;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        first_addr = 5'($urandom);
        num_instr = 6'($urandom);
        got = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            start = (extra && c == 15) ? 1'b1 : 1'b0;
            if (done_total > d0) got = 1;
            else begin @(posedge clk); #1; end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        last_lat = done_cyc - t0;
        check({tag, "_latency"}, 64'(last_lat), 64'(1 + cyc_sum));
        check({tag, "_busy_cycles"}, 64'(busy_total - b0), 64'(cyc_sum + 1));
        check({tag, "_busy_low_after"}, 64'(busy), 64'd0);
        check({tag, "_err"}, 64'(err_count), 64'(exp_err));
        check({tag, "_nwrites"}, 64'(wlog_addr.size() - w0), 64'(ea.size()));
        for (int i = 0; i < ea.size() && w0 + i < wlog_addr.size(); i++) begin
            check($sformatf("%s_waddr%0d", tag, i), 64'(wlog_addr[w0 + i]), 64'(ea[i]));
            check($sformatf("%s_wres%0d", tag, i), wlog_res[w0 + i], er[i]);
        end
        check({tag, "_nreqs"}, 64'(rq_opc.size() - r0), 64'(eo.size()));
        for (int i = 0; i < eo.size() && r0 + i < rq_opc.size(); i++) begin
            check($sformatf("%s_req%0d", tag, i), {rq_opc[r0 + i], rq_a[r0 + i], rq_b[r0 + i]},
                  {eo[i], eqa[i], eqb[i]});
        end
        check({tag, "_stable"}, 64'(unstable), 64'd0);
        if (n == 6'd0) check({tag, "_rd_hold"}, 64'(rd_addr), 64'(rd_before));
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_one_done"}, 64'(done_total - d0), 64'd1);
        check({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int w0, d0;
        bit got;
        for (int i = 0; i < 32; i++) begin
            mem_opc[i] = '0;
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        set_fast();
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ADD
        mem_opc[3] = 4'd3; mem_a[3] = 32'd5; mem_b[3] = 32'hFFFF_FFF9;
        run_batch(5'd3, 6'd1, 1'b0, "add");
        check("add_lat6", 64'(last_lat), 64'd6);
        if (wlog_res.size() > 0) check("add_result", wlog_res[wlog_res.size() - 1], 64'hFFFF_FFFF_FFFF_FFFE);
        if (rq_b.size() > 0) check("add_req_b", 64'(rq_b[rq_b.size() - 1]), 64'hFFFF_FFF9);

        // Wrap-around, all PASSA
        for (int i = 0; i < 4; i++) begin
            mem_opc[(30 + i) % 32] = 4'd1;
            mem_a[(30 + i) % 32] = $urandom;
        end
        run_batch(5'd30, 6'd4, 1'b0, "wrap");

        // Local resolution
        mem_opc[10] = 4'd6;  mem_a[10] = 32'd9; mem_b[10] = 32'd0;
        mem_opc[11] = 4'd12; mem_a[11] = $urandom; mem_b[11] = $urandom;
        mem_opc[12] = 4'd0;  mem_a[12] = $urandom; mem_b[12] = $urandom;
        run_batch(5'd10, 6'd3, 1'b0, "local");
        check("local_lat", 64'(last_lat), 64'd10);
        check("local_err2", 64'(err_count), 64'd2);

        // Backpressure
        mem_opc[20] = 4'd4; mem_a[20] = $urandom; mem_b[20] = $urandom;
        stall_arr[0] = 4;
        run_batch(5'd20, 6'd1, 1'b0, "bp");
        check("bp_lat", 64'(last_lat), 64'd10);
        set_fast();

        // Empty batch
        run_batch(5'd17, 6'd0, 1'b0, "empty");

        // Random batches
        for (int t = 0; t < 6; t++) begin
            randomize_all();
            run_batch(5'($urandom), 6'($urandom_range(1, 33)), 1'b0, $sformatf("rnd%0d", t));
        end

        // Reset during WAIT of 2nd of 5
        set_fast();
        for (int i = 0; i < 5; i++) begin
            mem_opc[i] = 4'd3; mem_a[i] = $urandom; mem_b[i] = $urandom;
        end
        delay_arr[1] = 6;
        @(posedge clk); #1;
        batch_base = acc_total;
        w0 = wlog_addr.size();
        d0 = done_total;
        start = 1'b1; first_addr = 5'd0; num_instr = 6'd5;
        @(posedge clk); #1;
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            if (acc_total - batch_base >= 2) got = 1;
            else begin @(posedge clk); #1; end
        end
        check("rst_reached_wait", 64'(got), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        check("midrst_writes", 64'(wlog_addr.size() - w0), 64'd1);
        check("midrst_no_done", 64'(done_total - d0), 64'd0);
        check("midrst_idle", 64'(busy), 64'd0);

        randomize_all();
        run_batch(5'd9, 6'd7, 1'b0, "after_rst");

        // Clamp plus ignored start
        randomize_all();
        run_batch(5'd13, 6'd40, 1'b1, "clamp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
